monolith_axis_chunk_buffer: RTL and testbench

MONOLITH_AXIS_CHUNK_BUFFER -- requirements
Module: monolith_axis_chunk_buffer

---
 rtl/monolith_axis_chunk_buffer.sv | 118 +++++++++++
 tb/tb_monolith_axis_chunk_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monolith_axis_chunk_buffer.sv
// AXI-Stream to chunk buffer: collects stream words into fixed-size chunk slots
// and presents one whole chunk at a time through a registered output stage.
module monolith_axis_chunk_buffer #(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned CHUNK_SIZE           = 16,
  parameter int unsigned CHUNK_COUNT          = 4
) (
  input  logic                                    S_AXIS_ACLK,
  input  logic                                    S_AXIS_ARESET,
  input  logic                                    S_AXIS_TVALID,
  output logic                                    S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]         S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]       S_AXIS_TSTRB,
  input  logic                                    S_AXIS_TLAST,
  output logic                                    m_chunk_valid,
  input  logic                                    m_chunk_ready,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]         m_chunk_data [CHUNK_SIZE],
  output logic [$clog2(CHUNK_SIZE+1)-1:0]         m_chunk_len,
  output logic                                    m_chunk_last,
  output logic [$clog2(CHUNK_COUNT+1)-1:0]        slots_used
);

  localparam int unsigned W     = C_S_AXIS_TDATA_WIDTH;
  localparam int unsigned IdxW  = $clog2(CHUNK_SIZE);
  localparam int unsigned SlotW = $clog2(CHUNK_COUNT);
  localparam int unsigned LenW  = $clog2(CHUNK_SIZE + 1);
  localparam int unsigned UsedW = $clog2(CHUNK_COUNT + 1);

  logic [W-1:0]           mem [CHUNK_COUNT][CHUNK_SIZE];
  logic [LenW-1:0]        slot_len [CHUNK_COUNT];
  logic [CHUNK_COUNT-1:0] slot_last;
  logic [SlotW-1:0]       wr_slot;
  logic [SlotW-1:0]       rd_slot;
  logic [IdxW-1:0]        wr_idx;
  logic                   accept;
  logic                   commit;
  logic                   load;
  logic [W-1:0]           load_data [CHUNK_SIZE];

  // Byte qualifier carries no meaning for this buffer.
  logic unused_tstrb;
  assign unused_tstrb = ^S_AXIS_TSTRB;

  // Handshake decode; TREADY comes straight from registers so beats flow every cycle.
  always_comb begin
    S_AXIS_TREADY = !S_AXIS_ARESET && (slots_used < UsedW'(CHUNK_COUNT));
    accept        = S_AXIS_TVALID && S_AXIS_TREADY;
    commit        = accept && (S_AXIS_TLAST || (wr_idx == IdxW'(CHUNK_SIZE - 1)));
    // A load never targets the write slot: when the head is readable the write
    // slot differs from it unless storage is full, and then nothing is accepted.
    load          = (slots_used != '0) && (!m_chunk_valid || m_chunk_ready);
  end

  // Head slot with words past its length masked so stale contents never leak out.
  always_comb begin
    for (int i = 0; i < CHUNK_SIZE; i++) begin
      load_data[i] = (LenW'(i) < slot_len[rd_slot]) ? mem[rd_slot][i] : '0;
    end
  end

  // Word storage; needs no reset because lengths gate every read.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (accept) begin
      mem[wr_slot][wr_idx] <= S_AXIS_TDATA;
    end
  end

  // Pointers, slot metadata, occupancy and the output chunk register.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      wr_slot       <= '0;
      rd_slot       <= '0;
      wr_idx        <= '0;
      slots_used    <= '0;
      slot_last     <= '0;
      m_chunk_valid <= 1'b0;
      m_chunk_len   <= '0;
      m_chunk_last  <= 1'b0;
      for (int s = 0; s < CHUNK_COUNT; s++) begin
        slot_len[s] <= '0;
      end
      for (int i = 0; i < CHUNK_SIZE; i++) begin
        m_chunk_data[i] <= '0;
      end
    end else begin
      if (accept) begin
        if (commit) begin
          slot_len[wr_slot]  <= LenW'(wr_idx) + LenW'(1);
          slot_last[wr_slot] <= S_AXIS_TLAST;
          wr_idx             <= '0;
          wr_slot            <= wr_slot + SlotW'(1);
        end else begin
          wr_idx <= wr_idx + IdxW'(1);
        end
      end

      if (load) begin
        rd_slot       <= rd_slot + SlotW'(1);
        m_chunk_valid <= 1'b1;
        m_chunk_len   <= slot_len[rd_slot];
        m_chunk_last  <= slot_last[rd_slot];
        for (int i = 0; i < CHUNK_SIZE; i++) begin
          m_chunk_data[i] <= load_data[i];
        end
      end else if (m_chunk_valid && m_chunk_ready) begin
        m_chunk_valid <= 1'b0;
      end

      // Simultaneous commit and load cancel out.
      if (commit && !load) begin
        slots_used <= slots_used + UsedW'(1);
      end else if (load && !commit) begin
        slots_used <= slots_used - UsedW'(1);
      end
    end
  end

endmodule

// File: tb/tb_monolith_axis_chunk_buffer.sv
// Bench for monolith_axis_chunk_buffer: directed table, corner sequences and a
// randomized run checked against a queue-based chunk model.
module tb_monolith_axis_chunk_buffer;

  localparam int DW = 32;
  localparam int CS = 16;
  localparam int CC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic [3:0]    tstrb;
  logic          tlast;
  logic          mvalid;
  logic          mready;
  logic [DW-1:0] mdata [CS];
  logic [4:0]    mlen;
  logic          mlast;
  logic [2:0]    used;

  monolith_axis_chunk_buffer #(
    .C_S_AXIS_TDATA_WIDTH(DW),
    .CHUNK_SIZE(CS),
    .CHUNK_COUNT(CC)
  ) dut (
    .S_AXIS_ACLK(clk),
    .S_AXIS_ARESET(rst),
    .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready),
    .S_AXIS_TDATA(tdata),
    .S_AXIS_TSTRB(tstrb),
    .S_AXIS_TLAST(tlast),
    .m_chunk_valid(mvalid),
    .m_chunk_ready(mready),
    .m_chunk_data(mdata),
    .m_chunk_len(mlen),
    .m_chunk_last(mlast),
    .slots_used(used)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d [CS];
    int            len;
    bit            last;
  } chunk_t;

  // Reference model: a queue of committed chunks plus the word list being built.
  chunk_t        mq [$];
  logic [DW-1:0] cur [$];
  bit            m_valid;
  int            m_len;
  bit            m_last;
  logic [DW-1:0] m_data [CS];

  logic [DW-1:0] got [$];
  int            tready_low;
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    cur.delete();
    m_valid = 1'b0;
    m_len   = 0;
    m_last  = 1'b0;
    for (int i = 0; i < CS; i++) m_data[i] = '0;
  endtask

  // One clock: drive inputs, advance the model across the edge, compare at +1.
  task automatic step(input bit r, input bit v, input logic [DW-1:0] d, input bit l,
                      input bit rd);
    bit     m_acc;
    bit     m_load;
    chunk_t c;
    int     dbad;
    rst    = r;
    tvalid = v;
    tdata  = d;
    tlast  = l;
    mready = rd;
    tstrb  = 4'($urandom);
    m_acc  = v && !r && (mq.size() < CC);
    m_load = (mq.size() > 0) && (!m_valid || rd);
    #1;
    if (!r && !tready) tready_low++;
    if (!r && mvalid && rd) begin
      for (int i = 0; i < CS; i++) if (i < int'(mlen)) got.push_back(mdata[i]);
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (m_load) begin
        c       = mq.pop_front();
        m_valid = 1'b1;
        m_len   = c.len;
        m_last  = c.last;
        for (int i = 0; i < CS; i++) m_data[i] = (i < c.len) ? c.d[i] : '0;
      end else if (m_valid && rd) begin
        m_valid = 1'b0;
      end
      if (m_acc) begin
        cur.push_back(d);
        if (cur.size() == CS || l) begin
          c.len  = cur.size();
          c.last = l;
          for (int i = 0; i < CS; i++) c.d[i] = (i < c.len) ? cur[i] : '0;
          mq.push_back(c);
          cur.delete();
        end
      end
    end
    #1;
    chk("model_tready", longint'(tready), longint'(!r && (mq.size() < CC)));
    chk("model_valid", longint'(mvalid), longint'(m_valid));
    chk("model_used", longint'(used), longint'(mq.size()));
    if (m_valid) begin
      chk("model_len", longint'(mlen), longint'(m_len));
      chk("model_last", longint'(mlast), longint'(m_last));
      dbad = 0;
      for (int i = 0; i < CS; i++) if (mdata[i] !== m_data[i]) dbad++;
      chk("model_data_words_wrong", longint'(dbad), 0);
    end
  endtask

  typedef struct {
    bit            rst;
    bit            tvalid;
    logic [DW-1:0] tdata;
    bit            tlast;
    bit            ready;
    bit            e_tready;
    bit            e_valid;
    int            e_len;
    bit            e_last;
    int            e_used;
    bit            chk_data;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int sent;
    int cyc;
    int errs;
    int prob;
    logic [DW-1:0] w;

    rst = 1'b1; tvalid = 1'b0; tdata = '0; tlast = 1'b0; mready = 1'b0; tstrb = '0;
    tready_low = 0;
    model_reset();

    // Directed table: reset, five-beat packet, load, hold, release.
    tbl[0] = '{1, 0, 32'h0,  0, 1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 32'hA0, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 32'hA1, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 1, 32'hA2, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[4] = '{0, 1, 32'hA3, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[5] = '{0, 1, 32'hA4, 1, 1, 1, 0, 0, 0, 1, 0};
    tbl[6] = '{0, 0, 32'h0,  0, 0, 1, 1, 5, 1, 0, 1};
    tbl[7] = '{0, 0, 32'h0,  0, 0, 1, 1, 5, 1, 0, 1};
    tbl[8] = '{0, 0, 32'h0,  0, 1, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rst, tbl[i].tvalid, tbl[i].tdata, tbl[i].tlast, tbl[i].ready);
      chk($sformatf("tbl%0d_tready", i), longint'(tready), longint'(tbl[i].e_tready));
      chk($sformatf("tbl%0d_valid", i), longint'(mvalid), longint'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_used", i), longint'(used), longint'(tbl[i].e_used));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_len", i), longint'(mlen), longint'(tbl[i].e_len));
        chk($sformatf("tbl%0d_last", i), longint'(mlast), longint'(tbl[i].e_last));
      end
      if (tbl[i].chk_data) begin
        errs = 0;
        for (int k = 0; k < CS; k++) begin
          w = (k < 5) ? DW'(32'hA0 + k) : '0;
          if (mdata[k] !== w) errs++;
        end
        chk($sformatf("tbl%0d_data_words_wrong", i), longint'(errs), 0);
      end
    end

    // Full 16-beat packet: valid exactly one cycle after commit.
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < CS; i++) step(0, 1, DW'(i), (i == CS - 1), 1);
    chk("full_commit_used", longint'(used), 1);
    chk("full_commit_no_valid_yet", longint'(mvalid), 0);
    step(0, 0, 0, 0, 1);
    chk("full_valid", longint'(mvalid), 1);
    chk("full_len", longint'(mlen), 16);
    chk("full_last", longint'(mlast), 1);
    errs = 0;
    for (int k = 0; k < CS; k++) if (mdata[k] !== DW'(k)) errs++;
    chk("full_data_words_wrong", longint'(errs), 0);
    step(0, 0, 0, 0, 1);
    chk("full_valid_cleared", longint'(mvalid), 0);

    // Backpressure: fill all slots plus the output register.
    step(1, 0, 0, 0, 0);
    got.delete();
    sent = 0;
    cyc  = 0;
    while (sent < 80 && cyc < 300) begin
      bit will_acc;
      will_acc = (mq.size() < CC);
      step(0, 1, DW'(sent), 0, 0);
      if (will_acc) sent++;
      cyc++;
    end
    chk("fill_beats_accepted", longint'(sent), 80);
    chk("fill_tready_low", longint'(tready), 0);
    chk("fill_used_full", longint'(used), 4);
    chk("fill_out_valid", longint'(mvalid), 1);
    step(0, 1, DW'(sent), 0, 0);
    chk("fill_still_blocked", longint'(tready), 0);
    step(0, 1, DW'(sent), 0, 1);
    chk("fill_tready_after_load", longint'(tready), 1);
    chk("fill_used_after_load", longint'(used), 3);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
    chk("fill_words_out", longint'(got.size()), 80);
    errs = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== DW'(i)) errs++;
    chk("fill_order_errors", longint'(errs), 0);

    // Continuous streaming with the consumer always ready.
    step(1, 0, 0, 0, 1);
    got.delete();
    tready_low = 0;
    for (int i = 0; i < 66; i++) step(0, 1, DW'(32'h1000 + i), (i == 49), 1);
    chk("cont_tready_low_cycles", longint'(tready_low), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    chk("cont_words_out", longint'(got.size()), 66);
    errs = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== DW'(32'h1000 + i)) errs++;
    chk("cont_order_errors", longint'(errs), 0);

    // Reset with a partial chunk and two slots full.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 55; i++) step(0, 1, DW'(32'h5000 + i), 0, 0);
    chk("rst_pre_used", longint'(used), 2);
    step(1, 1, 32'hDEAD, 0, 0);
    chk("rst_valid", longint'(mvalid), 0);
    chk("rst_len", longint'(mlen), 0);
    chk("rst_last", longint'(mlast), 0);
    chk("rst_used", longint'(used), 0);
    chk("rst_tready", longint'(tready), 0);
    errs = 0;
    for (int k = 0; k < CS; k++) if (mdata[k] !== '0) errs++;
    chk("rst_data_nonzero_words", longint'(errs), 0);
    got.delete();
    for (int i = 0; i < CS; i++) step(0, 1, DW'(32'h100 + i), 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    chk("rst_next_words_out", longint'(got.size()), 16);
    errs = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== DW'(32'h100 + i)) errs++;
    chk("rst_next_data_errors", longint'(errs), 0);

    // Randomized traffic with varying consumer pressure and rare resets.
    step(1, 0, 0, 0, 0);
    prob = 90;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) prob = int'($urandom_range(0, 100));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), $urandom,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) < prob));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
